// File: rtl/instr_pkg.sv
// Shared constants for the MIPS instruction packer: format tags, field widths,
// FSM state encodings and the field-legality helper.
package instr_pkg;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_RSV = 2'd3;

    localparam int OP_W  = 6;
    localparam int REG_W = 5;
    localparam int FUN_W = 6;
    localparam int IMM_W = 16;
    localparam int TGT_W = 26;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    // R-type instructions carry op 0; I/J types must not.
    function automatic logic fmt_op_bad(input logic [1:0] fmt, input logic [OP_W-1:0] op);
        logic bad;
        case (fmt)
            FMT_R:   bad = (op != '0);
            FMT_I,
            FMT_J:   bad = (op == '0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/instr_pack_comb.sv
// Purely combinational packer: format tag plus MIPS fields -> 32-bit word.
module instr_pack_comb
    import instr_pkg::*;
(
    input  logic [1:0]       fmt,
    input  logic [OP_W-1:0]  op,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] shamt,
    input  logic [FUN_W-1:0] fun,
    input  logic [IMM_W-1:0] imm16,
    input  logic [TGT_W-1:0] target26,
    output logic [31:0]      word
);

    always_comb begin
        word = 32'h0000_0000;
        case (fmt)
            FMT_R:   word = {op, rs, rt, rd, shamt, fun};
            FMT_I:   word = {op, rs, rt, imm16};
            FMT_J:   word = {op, target26};
            default: word = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/instr_packer.sv
// Packs MIPS field bundles into words and streams them into IM at incrementing
// addresses. Optional field checking (err output) when INSTR_PACK_CHECK_EN is defined.
module instr_packer
    import instr_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       fmt,
    input  logic [OP_W-1:0]  op,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] shamt,
    input  logic [FUN_W-1:0] fun,
    input  logic [IMM_W-1:0] imm16,
    input  logic [TGT_W-1:0] target26,
    output logic             im_we,
    output logic [AW-1:0]    im_addr,
    output logic [31:0]      im_wdata,
    output logic [AW:0]      count,
    output logic             full
`ifdef INSTR_PACK_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [AW:0]   count_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   packed_word;
    logic          accept;

    instr_pack_comb u_pack (
        .fmt      (fmt),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .fun      (fun),
        .imm16    (imm16),
        .target26 (target26),
        .word     (packed_word)
    );

    assign in_ready = (state_reg == S_RUN);
    // clear outranks a simultaneous bundle, so it blocks the accept
    assign accept   = in_valid & in_ready & ~clear;

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (start) state_next = S_RUN;
                S_RUN:   if (accept && count_reg == LAST) state_next = S_FULL;
                S_FULL:  state_next = S_FULL;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            we_reg    <= accept;
            if (clear) begin
                count_reg <= '0;
            end else if (accept) begin
                count_reg <= count_reg + 1'b1;
            end
            if (accept) begin
                addr_reg  <= count_reg[AW-1:0];
                wdata_reg <= packed_word;
            end else if (clear) begin
                addr_reg  <= '0;
            end
        end
    end

`ifdef INSTR_PACK_CHECK_EN
    logic err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= accept & fmt_op_bad(fmt, op);
        end
    end

    assign err = err_reg;
`endif

    assign im_we    = we_reg;
    assign im_addr  = addr_reg;
    assign im_wdata = wdata_reg;
    assign count    = count_reg;
    assign full     = (state_reg == S_FULL);

endmodule

// File: tb/tb_instr_packer.sv
// Scoreboard bench for instr_packer: driver predicts writes from a behavioural
// model, a separate monitor pops and compares every IM write strobe.
module tb_instr_packer;

    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    fmt = '0;
    logic [5:0]    op = '0;
    logic [4:0]    rs = '0;
    logic [4:0]    rt = '0;
    logic [4:0]    rd = '0;
    logic [4:0]    shamt = '0;
    logic [5:0]    fun = '0;
    logic [15:0]   imm16 = '0;
    logic [25:0]   target26 = '0;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   count;
    logic          full;
`ifdef INSTR_PACK_CHECK_EN
    logic          err;
`endif

    instr_packer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fmt      (fmt),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .fun      (fun),
        .imm16    (imm16),
        .target26 (target26),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .count    (count),
        .full     (full)
`ifdef INSTR_PACK_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int unsigned addr;
        logic [31:0] word;
        bit          err;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // model state: 0 = idle, 1 = loading, 2 = memory filled
    int   m_mode = 0;
    int   m_count = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_word(input int f, input int o, input int s, input int t,
                                               input int d, input int sh, input int fn,
                                               input int im, input int tg);
        int unsigned w;
        case (f)
            0:       w = o * 2**26 + s * 2**21 + t * 2**16 + d * 2**11 + sh * 2**6 + fn;
            1:       w = o * 2**26 + s * 2**21 + t * 2**16 + im;
            2:       w = o * 2**26 + tg;
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic bit model_err(input int f, input int o);
        if (f == 3) return 1'b1;
        if (f == 0) return o != 0;
        return o == 0;
    endfunction

    // Monitor: every cycle either the predicted write appears or no strobe is present.
    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                void'(q.pop_front());
                chk("missed_write", 32'd0, 32'd1);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                exp_t e;
                e = q.pop_front();
                $display("WRITE cycle=%0d addr=%0d data=%h", cyc, im_addr, im_wdata);
                chk("write_we", {31'd0, im_we}, 32'd1);
                chk("write_addr", {27'd0, im_addr}, e.addr);
                chk("write_data", im_wdata, e.word);
`ifdef INSTR_PACK_CHECK_EN
                chk("write_err", {31'd0, err}, {31'd0, e.err});
`endif
            end else begin
                chk("no_strobe", {31'd0, im_we}, 32'd0);
`ifdef INSTR_PACK_CHECK_EN
                chk("no_err", {31'd0, err}, 32'd0);
`endif
            end
        end
    end

    // One cycle of stimulus, entered and left at a falling edge.
    task automatic step(input bit clr, input bit st, input bit vld, input int f, input int o,
                        input int s, input int t, input int d, input int sh, input int fn,
                        input int im, input int tg, input bit use_lit = 1'b0,
                        input logic [31:0] lit = 32'h0);
        exp_t e;
        chk("count", {26'd0, count}, m_count);
        chk("full", {31'd0, full}, {31'd0, m_mode == 2});
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_mode == 1});
        clear    = clr;
        start    = st;
        in_valid = vld;
        fmt      = f[1:0];
        op       = o[5:0];
        rs       = s[4:0];
        rt       = t[4:0];
        rd       = d[4:0];
        shamt    = sh[4:0];
        fun      = fn[5:0];
        imm16    = im[15:0];
        target26 = tg[25:0];
        if (clr) begin
            m_mode  = 0;
            m_count = 0;
        end else if (m_mode == 0) begin
            if (st) m_mode = 1;
        end else if (m_mode == 1 && vld) begin
            e.cyc  = cyc + 1;
            e.addr = m_count;
            e.word = use_lit ? lit : model_word(f, o, s, t, d, sh, fn, im, tg);
            e.err  = model_err(f, o);
            q.push_back(e);
            m_count++;
            if (m_count == DEPTH) m_mode = 2;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ctl(input bit clr, input bit st, input bit vld);
        step(clr, st, vld, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd_step(input bit clr, input bit st, input bit vld);
        step(clr, st, vld, $urandom_range(3), $urandom_range(63), $urandom_range(31),
             $urandom_range(31), $urandom_range(31), $urandom_range(31), $urandom_range(63),
             $urandom_range(65535), $urandom & 32'h03FF_FFFF);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, {31'd0, im_we}, 32'd0);
        chk({tag, "_addr"}, {27'd0, im_addr}, 32'd0);
        chk({tag, "_wdata"}, im_wdata, 32'd0);
        chk({tag, "_count"}, {26'd0, count}, 32'd0);
        chk({tag, "_full"}, {31'd0, full}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // bundle offered while idle is ignored, then start
        rnd_step(0, 0, 1);
        ctl(0, 1, 0);
        step(0, 0, 1, 0, 0, 1, 2, 3, 0, 32'h20, 0, 0, 1'b1, 32'h0022_1820);
        step(0, 0, 1, 1, 32'h23, 29, 8, 0, 0, 0, 4, 0, 1'b1, 32'h8FA8_0004);
        step(0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, 32'h010_0000, 1'b1, 32'h0810_0000);
        // fill to DEPTH, then two more offers that must be dropped
        for (int i = 0; i < 3; i++) rnd_step(0, 1, 1);
        ctl(0, 0, 0);

        // clear together with a bundle while running
        ctl(1, 0, 0);
        ctl(0, 1, 0);
        rnd_step(0, 0, 1);
        rnd_step(1, 0, 1);
        ctl(0, 1, 0);
        rnd_step(0, 0, 1);
        ctl(0, 0, 0);

        // asynchronous reset in the middle of back-to-back writes
        ctl(1, 0, 0);
        ctl(0, 1, 0);
        rnd_step(0, 0, 1);
        rnd_step(0, 0, 1);
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        q.delete();
        m_mode  = 0;
        m_count = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rnd_step(0, 0, 1);
        rnd_step(0, 0, 1);
        ctl(0, 1, 0);
        rnd_step(0, 0, 1);

`ifdef INSTR_PACK_CHECK_EN
        ctl(1, 0, 0);
        ctl(0, 1, 0);
        step(0, 0, 1, 0, 8, 1, 2, 3, 0, 32'h20, 0, 0);
        step(0, 0, 1, 3, 5, 1, 2, 3, 4, 5, 6, 7, 1'b1, 32'h0000_0000);
        step(0, 0, 1, 1, 32'h23, 29, 8, 0, 0, 0, 4, 0);
        step(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 32'h123);
`endif

        for (int i = 0; i < 400; i++) begin
            rnd_step(($urandom_range(19) == 0), ($urandom_range(3) == 0), ($urandom_range(3) != 0));
        end
        ctl(0, 0, 0);
        ctl(0, 0, 0);
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
